// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg: shared memory map for the Hack CPU data port.
//   ADDR_LED / ADDR_BUT : IO register addresses just above the 2K RAM window
//   RAM_TOP             : highest RAM address
//   BUT_PRESS_LSB       : bit position of the press flags in the button word
//   sel_t               : one-hot-or-zero region select carried to the read stage
package mmio_bridge_pkg;

  localparam logic [15:0] ADDR_LED      = 16'd2048;
  localparam logic [15:0] ADDR_BUT      = 16'd2049;
  localparam logic [15:0] RAM_TOP       = 16'd2047;
  localparam int          BUT_PRESS_LSB = 8;

  typedef struct packed {
    logic ram;
    logic led;
    logic but;
  } sel_t;

  // All-zero select marks an unmapped address.
  localparam sel_t SEL_NONE = 3'b000;

endpackage

// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if: CPU data port and RAM port bundled for the bridge.
//   CPU side : addressM, dataW, loadM, CLK_CPU, CLK_COUNT in; dataR out
//   RAM side : ram_address, ram_dataW, ram_loadM out; ram_dataR in
//   master   : environment view (CPU plus RAM block)
//   slave    : bridge view
interface mmio_bridge_if;

  logic [15:0] addressM;
  logic [15:0] dataW;
  logic        loadM;
  logic        CLK_CPU;
  logic [31:0] CLK_COUNT;
  logic [15:0] dataR;
  logic [10:0] ram_address;
  logic [15:0] ram_dataW;
  logic        ram_loadM;
  logic [15:0] ram_dataR;

  modport master (
    output addressM, dataW, loadM, CLK_CPU, CLK_COUNT, ram_dataR,
    input  dataR, ram_address, ram_dataW, ram_loadM
  );

  modport slave (
    input  addressM, dataW, loadM, CLK_CPU, CLK_COUNT, ram_dataR,
    output dataR, ram_address, ram_dataW, ram_loadM
  );

endinterface

// File: rtl/mmio_bridge_button_debounce.sv
// button_debounce: 2-flop synchroniser, shared-counter debouncer and
// write-1-to-clear press latch for NBUT raw buttons.
//   i_clk, i_rst : system clock, async active-high reset
//   i_but        : raw asynchronous buttons
//   i_clr        : per-bit press clear strobe
//   o_deb        : debounced level
//   o_press      : latched press flags (set on debounced rising edge)
module button_debounce #(
  parameter int NBUT            = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NBUT-1:0] i_but,
  input  logic [NBUT-1:0] i_clr,
  output logic [NBUT-1:0] o_deb,
  output logic [NBUT-1:0] o_press
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NBUT-1:0] r_meta;
  logic [NBUT-1:0] r_sync;
  logic [NBUT-1:0] r_deb;
  logic [NBUT-1:0] r_press;
  logic [CW-1:0]   r_cnt;
  logic            w_update;
  logic [NBUT-1:0] w_rise;

  // The debounced word takes the synchronised word once the counter expires.
  assign w_update = (r_sync != r_deb) && (r_cnt == CNT_MAX);
  assign w_rise   = w_update ? (r_sync & ~r_deb) : {NBUT{1'b0}};

  // Synchroniser, stability counter and debounced level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= {NBUT{1'b0}};
      r_sync <= {NBUT{1'b0}};
      r_deb  <= {NBUT{1'b0}};
      r_cnt  <= {CW{1'b0}};
    end else begin
      r_meta <= i_but;
      r_sync <= r_meta;
      if (r_sync == r_deb) begin
        r_cnt <= {CW{1'b0}};
      end else if (w_update) begin
        r_deb <= r_sync;
        r_cnt <= {CW{1'b0}};
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Press latch: a rising edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_press <= {NBUT{1'b0}};
    end else begin
      r_press <= (r_press & ~i_clr) | w_rise;
    end
  end

  assign o_deb   = r_deb;
  assign o_press = r_press;

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: address decode and memory-mapped IO between the Hack CPU data
// port and the 2K x 16 RAM.
//   CLK_100MHz, RST : system clock, async active-high reset
//   bus             : CPU data port and RAM port (slave view)
//   led             : LED register drive (address 2048)
//   but             : raw buttons (read back through address 2049)
// Read data has one cycle of latency for both RAM and IO so the CPU sees a
// single uniform timing.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int NLED            = 2,
  parameter int NBUT            = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int WR_SLOT         = 10
) (
  input  logic            CLK_100MHz,
  input  logic            RST,
  mmio_bridge_if.slave    bus,
  output logic [NLED-1:0] led,
  input  logic [NBUT-1:0] but
);

  sel_t            w_sel;
  logic            w_wr_stb;
  logic [NBUT-1:0] w_clr;
  logic [NBUT-1:0] w_deb;
  logic [NBUT-1:0] w_press;
  logic [15:0]     w_io_word;
  logic [NLED-1:0] r_led;
  sel_t            r_sel;
  logic [15:0]     r_io;

  assign w_sel.ram = (bus.addressM <= RAM_TOP);
  assign w_sel.led = (bus.addressM == ADDR_LED);
  assign w_sel.but = (bus.addressM == ADDR_BUT);

  // One pulse per CPU cycle, on the same phase slot the RAM commits on.
  assign w_wr_stb = bus.loadM & bus.CLK_CPU & (bus.CLK_COUNT == 32'(WR_SLOT));

  assign bus.ram_address = bus.addressM[10:0];
  assign bus.ram_dataW   = bus.dataW;
  assign bus.ram_loadM   = bus.loadM & w_sel.ram;

  assign w_clr = (w_wr_stb & w_sel.but) ? bus.dataW[BUT_PRESS_LSB +: NBUT] : {NBUT{1'b0}};

  button_debounce #(
    .NBUT            (NBUT),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .i_clk   (CLK_100MHz),
    .i_rst   (RST),
    .i_but   (but),
    .i_clr   (w_clr),
    .o_deb   (w_deb),
    .o_press (w_press)
  );

  // LED register; only the low NLED data bits are kept.
  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      r_led <= {NLED{1'b0}};
    end else if (w_wr_stb && w_sel.led) begin
      r_led <= bus.dataW[NLED-1:0];
    end else begin
      r_led <= r_led;
    end
  end

  assign led = r_led;

  // IO read word for the current address, zero for anything that is not IO.
  always_comb begin
    w_io_word = 16'h0000;
    if (w_sel.led) begin
      w_io_word[NLED-1:0] = r_led;
    end else if (w_sel.but) begin
      w_io_word[BUT_PRESS_LSB +: NBUT] = w_press;
      w_io_word[NBUT-1:0]              = w_deb;
    end else begin
      w_io_word = 16'h0000;
    end
  end

  // Read stage: capture the region select and IO word alongside the RAM read.
  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      r_sel <= SEL_NONE;
      r_io  <= 16'h0000;
    end else begin
      r_sel <= w_sel;
      r_io  <= w_io_word;
    end
  end

  assign bus.dataR = r_sel.ram               ? bus.ram_dataR :
                     (r_sel.led | r_sel.but) ? r_io          : 16'h0000;

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;

  logic        clk;
  logic        rst;
  logic [1:0]  led;
  logic [1:0]  but;
  logic [15:0] mem [0:2047];
  int          n_cmp;
  int          n_err;

  mmio_bridge_if bus ();

  mmio_bridge #(
    .NLED            (2),
    .NBUT            (2),
    .DEBOUNCE_CYCLES (8),
    .WR_SLOT         (10)
  ) dut (
    .CLK_100MHz (clk),
    .RST        (rst),
    .bus        (bus),
    .led        (led),
    .but        (but)
  );

  always #5 clk = ~clk;

  // RAM block model: registered read, commits only on the write slot
  always @(posedge clk) begin
    if (bus.ram_loadM && bus.CLK_CPU && bus.CLK_COUNT == 32'd10)
      mem[bus.ram_address] <= bus.ram_dataW;
    bus.ram_dataR <= mem[bus.ram_address];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [15:0] a, input logic [15:0] d, input logic [31:0] slot);
    bus.addressM  = a;
    bus.dataW     = d;
    bus.loadM     = 1'b1;
    bus.CLK_CPU   = 1'b1;
    bus.CLK_COUNT = slot;
  endtask

  task automatic idle(input logic [15:0] a);
    bus.addressM  = a;
    bus.loadM     = 1'b0;
    bus.CLK_CPU   = 1'b0;
    bus.CLK_COUNT = 32'd0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (led !== 2'b00) begin n_err++; $display("FAIL reset_led: got %b want 00", led); end
    n_cmp++; if (bus.dataR !== 16'h0000) begin n_err++; $display("FAIL reset_dataR: got %h want 0000", bus.dataR); end
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++; if (bus.dataR !== 16'h0000) begin n_err++; $display("FAIL post_reset_read0: got %h want 0000", bus.dataR); end
  endtask

  task automatic test_ram();
    drive_write(16'd5, 16'h1234, 32'd10);
    #1;
    n_cmp++; if (bus.ram_loadM !== 1'b1) begin n_err++; $display("FAIL ram_loadM: got %b want 1", bus.ram_loadM); end
    n_cmp++; if (bus.ram_address !== 11'd5) begin n_err++; $display("FAIL ram_address: got %0d want 5", bus.ram_address); end
    n_cmp++; if (bus.ram_dataW !== 16'h1234) begin n_err++; $display("FAIL ram_dataW: got %h want 1234", bus.ram_dataW); end
    step();
    idle(16'd5);
    step();
    n_cmp++; if (bus.dataR !== 16'h1234) begin n_err++; $display("FAIL ram_read5: got %h want 1234", bus.dataR); end
    drive_write(16'd2047, 16'hBEEF, 32'd10);
    step();
    idle(16'd2047);
    step();
    n_cmp++; if (bus.dataR !== 16'hBEEF) begin n_err++; $display("FAIL ram_read2047: got %h want beef", bus.dataR); end
    // off-slot RAM write is passed through ungated
    drive_write(16'd6, 16'h0BAD, 32'd9);
    #1;
    n_cmp++; if (bus.ram_loadM !== 1'b1) begin n_err++; $display("FAIL ram_loadM_noslot: got %b want 1", bus.ram_loadM); end
    step();
    idle(16'd5);
    step();
  endtask

  task automatic test_led();
    drive_write(16'd2048, 16'hFFFE, 32'd10);
    #1;
    n_cmp++; if (bus.ram_loadM !== 1'b0) begin n_err++; $display("FAIL led_ram_loadM: got %b want 0", bus.ram_loadM); end
    step();
    idle(16'd2048);
    n_cmp++; if (led !== 2'b10) begin n_err++; $display("FAIL led_write: got %b want 10", led); end
    drive_write(16'd2048, 16'h0001, 32'd9);
    #1;
    n_cmp++; if (bus.ram_loadM !== 1'b0) begin n_err++; $display("FAIL led_slot9_ram_loadM: got %b want 0", bus.ram_loadM); end
    step();
    idle(16'd2048);
    n_cmp++; if (led !== 2'b10) begin n_err++; $display("FAIL led_slot9: got %b want 10", led); end
    step();
    n_cmp++; if (bus.dataR !== 16'h0002) begin n_err++; $display("FAIL led_read: got %h want 0002", bus.dataR); end
    drive_write(16'd2048, 16'h0001, 32'd10);
    step();
    idle(16'd2048);
    n_cmp++; if (bus.dataR !== 16'h0002) begin n_err++; $display("FAIL led_read_old: got %h want 0002", bus.dataR); end
    n_cmp++; if (led !== 2'b01) begin n_err++; $display("FAIL led_write2: got %b want 01", led); end
    step();
    n_cmp++; if (bus.dataR !== 16'h0001) begin n_err++; $display("FAIL led_read_new: got %h want 0001", bus.dataR); end
  endtask

  task automatic test_unmapped();
    // 3000 aliases RAM word 952 in its low address bits
    drive_write(16'd952, 16'h5555, 32'd10);
    step();
    drive_write(16'd3000, 16'hAAAA, 32'd10);
    #1;
    n_cmp++; if (bus.ram_loadM !== 1'b0) begin n_err++; $display("FAIL unmapped_ram_loadM: got %b want 0", bus.ram_loadM); end
    step();
    idle(16'd3000);
    n_cmp++; if (led !== 2'b01) begin n_err++; $display("FAIL unmapped_led: got %b want 01", led); end
    step();
    n_cmp++; if (bus.dataR !== 16'h0000) begin n_err++; $display("FAIL unmapped_read: got %h want 0000", bus.dataR); end
    idle(16'd952);
    step();
    n_cmp++; if (bus.dataR !== 16'h5555) begin n_err++; $display("FAIL unmapped_alias: got %h want 5555", bus.dataR); end
  endtask

  task automatic test_debounce();
    idle(16'd2049);
    for (int k = 0; k < 10; k++) begin
      but[0] = (k % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        step();
        n_cmp++; if (bus.dataR !== 16'h0000) begin n_err++; $display("FAIL bounce k=%0d: got %h want 0000", k, bus.dataR); end
      end
    end
    but[0] = 1'b1;
    // deb rises at edge 10; the read word shows it one edge later
    for (int e = 1; e <= 10; e++) begin
      step();
      n_cmp++; if (bus.dataR !== 16'h0000) begin n_err++; $display("FAIL settle e=%0d: got %h want 0000", e, bus.dataR); end
    end
    step();
    n_cmp++; if (bus.dataR !== 16'h0101) begin n_err++; $display("FAIL debounce_rise: got %h want 0101", bus.dataR); end
  endtask

  task automatic test_press_clear();
    drive_write(16'd2049, 16'h0100, 32'd10);
    step();
    idle(16'd2049);
    n_cmp++; if (bus.dataR !== 16'h0101) begin n_err++; $display("FAIL clear_same_cycle: got %h want 0101", bus.dataR); end
    step();
    n_cmp++; if (bus.dataR !== 16'h0001) begin n_err++; $display("FAIL press_clear: got %h want 0001", bus.dataR); end
    but[0] = 1'b0;
    repeat (11) step();
    n_cmp++; if (bus.dataR !== 16'h0000) begin n_err++; $display("FAIL deb_fall: got %h want 0000", bus.dataR); end
    but[0] = 1'b1;
    repeat (9) step();
    drive_write(16'd2049, 16'h0100, 32'd10);
    step();
    idle(16'd2049);
    step();
    n_cmp++; if (bus.dataR !== 16'h0101) begin n_err++; $display("FAIL set_wins: got %h want 0101", bus.dataR); end
  endtask

  task automatic test_async_reset();
    drive_write(16'd2048, 16'h0003, 32'd10);
    step();
    idle(16'd2048);
    n_cmp++; if (led !== 2'b11) begin n_err++; $display("FAIL led_11: got %b want 11", led); end
    but = 2'b10;
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (led !== 2'b00) begin n_err++; $display("FAIL async_led: got %b want 00", led); end
    n_cmp++; if (bus.dataR !== 16'h0000) begin n_err++; $display("FAIL async_dataR: got %h want 0000", bus.dataR); end
    step(); step();
    rst = 1'b0;
    idle(16'd2049);
    for (int e = 1; e <= 10; e++) begin
      step();
      n_cmp++; if (bus.dataR !== 16'h0000) begin n_err++; $display("FAIL rst_settle e=%0d: got %h want 0000", e, bus.dataR); end
    end
    step();
    n_cmp++; if (bus.dataR !== 16'h0202) begin n_err++; $display("FAIL rst_deb: got %h want 0202", bus.dataR); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    but   = 2'b00;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    bus.ram_dataR = 16'h0000;
    bus.dataW     = 16'h0000;
    idle(16'd0);
    test_reset();
    test_ram();
    test_led();
    test_unmapped();
    test_debounce();
    test_press_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
